// File: rtl/uart_frame_scheduler.sv
`timescale 1ns/1ps
// Frame FIFO between the n-byte receiver and the n-byte sender: buffers whole
// frames and hands them out one at a time over the send-enable/busy handshake.
module uart_frame_scheduler #(
  parameter int BYTE_NUM     = 4,
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 1024,
  parameter int GAP_CYCLES   = 2,
  localparam int FW = 8 * BYTE_NUM,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rx_valid_i,
  input  logic          rx_error_i,
  input  logic [FW-1:0] rx_data_i,
  input  logic          tx_busy_i,
  input  logic          clr_i,
  output logic          tx_send_en_o,
  output logic [FW-1:0] tx_data_o,
  output logic [CW-1:0] pending_o,
  output logic          overflow_o,
  output logic [7:0]    drop_cnt_o,
  output logic          timeout_o
);

  localparam int TW = $clog2(BUSY_TIMEOUT);
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] FULL       = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, SENDING, GAP} state_t;

  state_t        state;
  logic [FW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap_cnt;
  logic          push;
  logic          full_drop;
  logic          timeout_hit;
  logic          pop;
  logic [1:0]    drop_inc;
  logic [7:0]    drop_base;
  logic [8:0]    drop_sum;

  assign pending_o = count;

  // The in-flight frame stays in the FIFO until the sender finishes or gives up,
  // so a full FIFO rejects new frames even on the cycle the head leaves.
  always_comb begin
    push        = rx_valid_i & ~rx_error_i & (count != FULL);
    full_drop   = rx_valid_i & ~rx_error_i & (count == FULL);
    timeout_hit = (state == ISSUE) & ~tx_busy_i & (timer == TIMER_LAST);
    pop         = ((state == SENDING) & ~tx_busy_i) | timeout_hit;
    drop_inc    = 2'(full_drop) + 2'(rx_error_i) + 2'(timeout_hit);
    drop_base   = clr_i ? 8'd0 : drop_cnt_o;
    drop_sum    = {1'b0, drop_base} + {7'd0, drop_inc};
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= rx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      timer        <= '0;
      gap_cnt      <= '0;
      tx_send_en_o <= 1'b0;
      tx_data_o    <= '0;
      overflow_o   <= 1'b0;
      drop_cnt_o   <= 8'd0;
      timeout_o    <= 1'b0;
    end else begin
      timeout_o  <= 1'b0;
      overflow_o <= (overflow_o & ~clr_i) | full_drop;
      drop_cnt_o <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);

      case (state)
        IDLE: begin
          if (count != '0) begin
            state        <= ISSUE;
            tx_data_o    <= mem[rd_ptr];
            tx_send_en_o <= 1'b1;
            timer        <= '0;
          end
        end
        ISSUE: begin
          if (tx_busy_i) begin
            state        <= SENDING;
            tx_send_en_o <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            state        <= IDLE;
            tx_send_en_o <= 1'b0;
            timeout_o    <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        SENDING: begin
          if (!tx_busy_i) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else gap_cnt <= gap_cnt + GW'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
`timescale 1ns/1ps
// Self-checking bench for uart_frame_scheduler: directed scenarios plus a random
// phase, checked against a queue-based model of the frame buffer and drop status.
module tb_uart_frame_scheduler;

  localparam int DEPTH = 4;
  localparam int BT    = 16;
  localparam int GAP   = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_valid_i = 1'b0;
  logic        rx_error_i = 1'b0;
  logic [31:0] rx_data_i = '0;
  logic        tx_busy_i = 1'b0;
  logic        clr_i = 1'b0;
  logic        tx_send_en_o;
  logic [31:0] tx_data_o;
  logic [2:0]  pending_o;
  logic        overflow_o;
  logic [7:0]  drop_cnt_o;
  logic        timeout_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] mq[$];
  int          m_drops = 0;
  bit          m_ovf = 0;

  always #5 clk_i = ~clk_i;

  uart_frame_scheduler #(
    .BYTE_NUM(4), .DEPTH(DEPTH), .BUSY_TIMEOUT(BT), .GAP_CYCLES(GAP)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_valid_i(rx_valid_i), .rx_error_i(rx_error_i),
    .rx_data_i(rx_data_i), .tx_busy_i(tx_busy_i), .clr_i(clr_i),
    .tx_send_en_o(tx_send_en_o), .tx_data_o(tx_data_o), .pending_o(pending_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .timeout_o(timeout_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus; the model applies the buffer/drop rules to the same inputs.
  task automatic applyStimulus(input logic v, input logic e, input logic [31:0] d,
                               input logic busy, input logic clr, input bit pop, input bit tmo);
    int       add;
    bit       full_drop;
    logic [31:0] dummy;
    add = 0;
    full_drop = 0;
    rx_valid_i = v; rx_error_i = e; rx_data_i = d; tx_busy_i = busy; clr_i = clr;
    if (e) add++;
    else if (v) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else begin add++; full_drop = 1; end
    end
    if (tmo) add++;
    if (clr) begin m_drops = 0; m_ovf = 0; end
    if (full_drop) m_ovf = 1;
    m_drops = (m_drops + add > 255) ? 255 : m_drops + add;
    if (pop && mq.size() > 0) dummy = mq.pop_front();
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0; rx_error_i = 1'b0; clr_i = 1'b0;
    checkOutput("pending", 32'(pending_o), mq.size());
    checkOutput("overflow", 32'(overflow_o), 32'(m_ovf));
    checkOutput("drop_cnt", 32'(drop_cnt_o), m_drops);
    checkOutput("timeout", 32'(timeout_o), 32'(tmo));
  endtask

  task automatic step(input logic busy, input bit pop, input bit tmo, input bit rnd);
    logic v, e;
    int   r;
    v = 0; e = 0;
    if (rnd) begin
      r = $urandom_range(0, 15);
      v = (r <= 4);
      e = (r == 4);
    end
    applyStimulus(v, e, $urandom(), busy, 1'b0, pop, tmo);
  endtask

  task automatic pushFrame(input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    rst_i = 1'b1; rx_valid_i = 0; rx_error_i = 0; tx_busy_i = 0; clr_i = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    mq.delete(); m_drops = 0; m_ovf = 0;
    checkOutput("rst_en", 32'(tx_send_en_o), 0);
    checkOutput("rst_pending", 32'(pending_o), 0);
    checkOutput("rst_ovf", 32'(overflow_o), 0);
    checkOutput("rst_drops", 32'(drop_cnt_o), 0);
    checkOutput("rst_timeout", 32'(timeout_o), 0);
    checkOutput("rst_data", tx_data_o, 0);
  endtask

  task automatic waitEnable(input bit rnd, output bit seen);
    seen = 0;
    for (int i = 0; i < 64; i++) begin
      if (tx_send_en_o) begin seen = 1; break; end
      step(1'b0, 1'b0, 1'b0, rnd);
    end
    checkOutput("en_seen", 32'(seen), 1);
  endtask

  // Sender behaviour: accept the issued frame, stay busy, release, then watch the gap.
  task automatic serveFrame(input int hold, input bit rnd, input bit pop_push,
                            input logic [31:0] pop_data);
    bit seen;
    int pre;
    logic [31:0] head;
    waitEnable(rnd, seen);
    if (!seen) return;
    checkOutput("en_vs_pending", 32'(tx_send_en_o), 32'(mq.size() != 0));
    if (mq.size() == 0) return;
    head = mq[0];
    checkOutput("tx_data", tx_data_o, head);
    step(1'b1, 1'b0, 1'b0, rnd);
    checkOutput("en_after_busy", 32'(tx_send_en_o), 0);
    for (int i = 1; i < hold; i++) begin
      step(1'b1, 1'b0, 1'b0, rnd);
      checkOutput("data_stable", tx_data_o, head);
    end
    if (pop_push) applyStimulus(1'b1, 1'b0, pop_data, 1'b0, 1'b0, 1'b1, 1'b0);
    else step(1'b0, 1'b1, 1'b0, rnd);
    for (int g = 0; g < GAP; g++) begin
      step(1'b0, 1'b0, 1'b0, rnd);
      checkOutput("gap_en", 32'(tx_send_en_o), 0);
    end
    pre = mq.size();
    step(1'b0, 1'b0, 1'b0, rnd);
    checkOutput("post_gap_en", 32'(tx_send_en_o), 32'(pre > 0));
  endtask

  // Sender never answers: the frame must be abandoned BT cycles after issue.
  task automatic serveTimeout(input bit err_at_timeout);
    bit seen;
    waitEnable(1'b0, seen);
    if (!seen) return;
    if (mq.size() > 0) checkOutput("to_data", tx_data_o, mq[0]);
    for (int i = 1; i < BT; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("to_en_held", 32'(tx_send_en_o), 1);
    end
    applyStimulus(1'b0, err_at_timeout, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("to_en_drop", 32'(tx_send_en_o), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    doReset();

    // Single frame: latency, handshake, pop and gap
    pushFrame(32'h44332211);
    checkOutput("t1_en_early", 32'(tx_send_en_o), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_en", 32'(tx_send_en_o), 1);
    checkOutput("t1_data", tx_data_o, 32'h44332211);
    serveFrame(5, 1'b0, 1'b0, 32'h0);

    // Burst of six into a four-deep FIFO, slow sender
    for (int k = 1; k <= 6; k++) pushFrame(32'hA0B0C000 + 32'(k));
    for (int k = 0; k < 4; k++) serveFrame(100, 1'b0, 1'b0, 32'h0);
    checkOutput("t2_ovf", 32'(overflow_o), 1);
    checkOutput("t2_drops", 32'(drop_cnt_o), 2);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_clr_ovf", 32'(overflow_o), 0);
    checkOutput("t2_clr_drops", 32'(drop_cnt_o), 0);

    // Push coinciding with pop: full FIFO drops, count 3 stays 3
    for (int k = 0; k < 4; k++) pushFrame(32'h33000000 + 32'(k));
    serveFrame(3, 1'b0, 1'b1, 32'h3300DEAD);
    checkOutput("t3_full_pending", 32'(pending_o), 3);
    checkOutput("t3_full_drops", 32'(drop_cnt_o), 1);
    serveFrame(3, 1'b0, 1'b1, 32'h3300BEEF);
    checkOutput("t3_three_pending", 32'(pending_o), 3);

    // Busy timeout, recovery through IDLE, timeout coinciding with an error
    doReset();
    pushFrame(32'h0000AAAA);
    pushFrame(32'h0000BBBB);
    serveTimeout(1'b0);
    checkOutput("t4_drops", 32'(drop_cnt_o), 1);
    checkOutput("t4_pending", 32'(pending_o), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_reissue_en", 32'(tx_send_en_o), 1);
    checkOutput("t4_reissue_data", tx_data_o, 32'h0000BBBB);
    serveFrame(3, 1'b0, 1'b0, 32'h0);
    pushFrame(32'h0000CCCC);
    serveTimeout(1'b1);
    checkOutput("t4_double_drop", 32'(drop_cnt_o), 3);

    // Parity errors: no push, counted, saturating; clear loses to same-cycle drop
    applyStimulus(1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_err_pending", 32'(pending_o), 0);
    for (int k = 0; k < 300; k++)
      applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_saturate", 32'(drop_cnt_o), 255);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_clr_vs_err", 32'(drop_cnt_o), 1);

    // Reset while sending with three pending
    doReset();
    for (int k = 0; k < 3; k++) pushFrame(32'h66000000 + 32'(k));
    begin
      bit seen;
      waitEnable(1'b0, seen);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    doReset();
    pushFrame(32'h77777777);
    checkOutput("t6_en_early", 32'(tx_send_en_o), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_en", 32'(tx_send_en_o), 1);
    checkOutput("t6_data", tx_data_o, 32'h77777777);
    serveFrame(2, 1'b0, 1'b0, 32'h0);

    // Random traffic against the model, then drain
    for (int n = 0; n < 12; n++) begin
      if (mq.size() == 0) pushFrame($urandom());
      serveFrame($urandom_range(1, 8), 1'b1, 1'b0, 32'h0);
    end
    for (int n = 0; n < 8 && mq.size() > 0; n++)
      serveFrame($urandom_range(1, 4), 1'b0, 1'b0, 32'h0);
    checkOutput("drain_pending", 32'(pending_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
